// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller: data type
// encodings, read/write polarity, controller states and small helpers.
package mem_pkg;

    localparam logic [1:0] DT_BYTE  = 2'b00;
    localparam logic [1:0] DT_HALF  = 2'b01;
    localparam logic [1:0] DT_WORD  = 2'b10;
    localparam logic [1:0] DT_DWORD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SETUP,
        STROBE,
        RELEASE,
        DONE
    } state_t;

    // Halfwords need an even address, words and doublewords a multiple of four.
    function automatic logic isMisaligned(input logic [1:0] dtype, input logic [1:0] lowAddr);
        logic bad;
        bad = 1'b0;
        case (dtype)
            DT_HALF:           bad = lowAddr[0];
            DT_WORD, DT_DWORD: bad = |lowAddr;
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Zero-pads narrow store data so unused memory lanes never see stale bits.
    function automatic logic [31:0] storeWord(input logic [1:0] dtype, input logic [31:0] data);
        logic [31:0] word;
        word = data;
        case (dtype)
            DT_BYTE: word = {24'b0, data[7:0]};
            DT_HALF: word = {16'b0, data[15:0]};
            default: word = data;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Formats a word returned by memory into the 64-bit load result:
// byte/halfword zero- or sign-extension, words zero-extended.
module load_extend
    import mem_pkg::*;
(
    input  logic [1:0]  dtype_i,
    input  logic        signedLd_i,
    input  logic [31:0] word_i,
    output logic [63:0] result_o
);

    // Pick the extension that matches the access size.
    always_comb begin
        result_o = {32'b0, word_i};
        case (dtype_i)
            DT_BYTE: result_o = signedLd_i ? {{56{word_i[7]}}, word_i[7:0]}
                                           : {56'b0, word_i[7:0]};
            DT_HALF: result_o = signedLd_i ? {{48{word_i[15]}}, word_i[15:0]}
                                           : {48'b0, word_i[15:0]};
            default: result_o = {32'b0, word_i};
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the MOV/MOC data-memory handshake. Takes one
// load/store from the datapath, checks alignment, runs one or two word
// transfers (doublewords are split) and reports rdata/err with a done pulse.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 15,
    parameter int MIN_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        dtype,
    input  logic              signed_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              MOV,
    output logic              ReadWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [1:0]        DataType,
    output logic [31:0]       MemDataOut,
    input  logic [31:0]       MemDataIn,
    input  logic              MOC
);

    localparam int CNT_MAX = (TIMEOUT > MIN_WAIT) ? TIMEOUT : MIN_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(4);

    state_t             state_q;
    logic               rw_q;
    logic [1:0]         dtype_q;
    logic               signedLd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [63:0]        wdata_q;
    logic               beat_q;
    logic [CNT_W-1:0]   waitCnt_q;
    logic [CNT_W-1:0]   waitCnt_d;
    logic [31:0]        word0_q;

    logic [63:0]        rdata_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               mov_q;
    logic               readWrite_q;
    logic [ADDR_W-1:0]  address_q;
    logic [1:0]         dataType_q;
    logic [31:0]        memDataOut_q;

    logic [63:0]        loadResult;
    logic               waitMet;
    logic               waitExpired;
    logic               isDword;

    load_extend uLoadExtend (
        .dtype_i    (dtype_q),
        .signedLd_i (signedLd_q),
        .word_i     (MemDataIn),
        .result_o   (loadResult)
    );

    // Wait counter advance and the two STROBE exit conditions it feeds.
    always_comb begin
        waitCnt_d   = waitCnt_q + CNT_W'(1);
        waitMet     = (waitCnt_d >= CNT_W'(MIN_WAIT)) && MOC;
        waitExpired = (waitCnt_d >= CNT_W'(TIMEOUT));
        isDword     = (dtype_q == DT_DWORD);
    end

    // Controller FSM; every bus and status output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rw_q         <= RW_WRITE;
            dtype_q      <= DT_BYTE;
            signedLd_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            beat_q       <= 1'b0;
            waitCnt_q    <= '0;
            word0_q      <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mov_q        <= 1'b0;
            readWrite_q  <= RW_WRITE;
            address_q    <= '0;
            dataType_q   <= DT_BYTE;
            memDataOut_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        rw_q       <= rw;
                        dtype_q    <= dtype;
                        signedLd_q <= signed_ld;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        beat_q     <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    if (isMisaligned(dtype_q, addr_q[1:0])) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        address_q    <= addr_q;
                        dataType_q   <= isDword ? DT_WORD : dtype_q;
                        readWrite_q  <= rw_q;
                        memDataOut_q <= storeWord(dtype_q, wdata_q[31:0]);
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    waitCnt_q <= '0;
                    mov_q     <= 1'b1;
                    state_q   <= STROBE;
                end
                STROBE: begin
                    if (waitMet) begin
                        mov_q   <= 1'b0;
                        state_q <= RELEASE;
                        if (rw_q == RW_READ) begin
                            if (!isDword) begin
                                rdata_q <= loadResult;
                            end else if (!beat_q) begin
                                word0_q <= MemDataIn;
                            end else begin
                                rdata_q <= {MemDataIn, word0_q};
                            end
                        end
                    end else if (waitExpired) begin
                        mov_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
                end
                RELEASE: begin
                    if (isDword && !beat_q) begin
                        beat_q       <= 1'b1;
                        address_q    <= address_q + BEAT_STRIDE;
                        memDataOut_q <= wdata_q[63:32];
                        state_q      <= SETUP;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign MOV        = mov_q;
    assign ReadWrite  = readWrite_q;
    assign Address    = address_q;
    assign DataType   = dataType_q;
    assign MemDataOut = memDataOut_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the byte-addressed 256x8 data memory's MOV/MOC handshake.
- Accepts one load/store request from the datapath, drives Address/DataType/ReadWrite/MOV, and waits for MOC.
- On loads, applies zero- or sign-extension; splits doubleword accesses into two word transfers.
- Sits between the control unit/datapath and the RAM.

Parameters:
- ADDR_W, 8: memory address width.
- TIMEOUT, 15: STROBE cycles without a valid MOC before aborting with error.
- MIN_WAIT, 1: minimum cycles MOV is held high before MOC is sampled.

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  start request, sampled in IDLE only
- rw  in  1  1=load, 0=store
- dtype  in  2  00 byte, 01 halfword, 10 word, 11 doubleword
- signed_ld  in  1  sign-extend byte/halfword loads
- addr  in  ADDR_W  byte address
- wdata  in  64  store data; [31:0] first word, [63:32] second (doubleword)
- rdata  out  64  load result, valid with done
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or timeout
- MOV  out  1  memory operation valid
- ReadWrite  out  1  1=read
- Address  out  ADDR_W  memory address
- DataType  out  2  always 00/01/10 to memory; doubleword issued as 10
- MemDataOut  out  32  store data to memory
- MemDataIn  in  32  load data from memory (big-endian packed)
- MOC  in  1  memory operation complete

Behaviour:
- Reset values: all outputs 0, state IDLE, beat 0. Reset mid-operation: MOV drops at the next edge, no done is generated, latched request is discarded.
- IDLE: on req=1, latch rw, dtype, signed_ld, addr, wdata; busy=1; go to CHECK. req while busy is ignored, not queued.
- CHECK (1 cycle): alignment check.
  - Halfword requires addr[0]=0; word and doubleword require addr[1:0]=0; byte is always aligned.
  - Misaligned: go to DONE with err=1 and MOV never asserted.
  - Otherwise go to SETUP.
- SETUP (1 cycle, MOV=0): drive Address, DataType (dtype, or 10 for doubleword), ReadWrite=rw, MemDataOut.
  - Byte store: MemDataOut = {24'b0, wdata[7:0]}.
  - Halfword store: {16'b0, wdata[15:0]}.
  - Word store: wdata[31:0].
  - Doubleword beat0/beat1: wdata[31:0] / wdata[63:32].
- STROBE: MOV=1, wait counter increments.
  - Once counter >= MIN_WAIT and MOC=1: capture MemDataIn into the beat's word (loads only), go to RELEASE.
  - Counter reaching TIMEOUT without that: go to DONE with err=1.
  - Address, DataType, ReadWrite and MemDataOut are stable for the whole of STROBE.
- RELEASE (1 cycle, MOV=0): the required low gap between accesses.
  - Doubleword with beat=0: beat=1, Address = Address+4 (mod 2^ADDR_W; 0xFC wraps to 0x00), go to SETUP.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0 on the next edge, return to IDLE. rdata and err hold until the next accept.
- Load formatting:
  - Byte: rdata = ext(MemDataIn[7:0]).
  - Halfword: rdata = ext(MemDataIn[15:0]).
  - ext is sign-extension to 64 bits if signed_ld, else zero-extension.
  - Word: {32'b0, word}.
  - Doubleword: rdata[31:0] = beat0 word, rdata[63:32] = beat1 word; signed_ld is ignored.
- Stores: rdata is unchanged.
- Minimum latency, accept to done: 5 cycles single-beat, 8 cycles doubleword, with MIN_WAIT=1 and MOC already high.

Decomposition:
- Shared package mem_pkg:
  - DataType encodings DT_BYTE/DT_HALF/DT_WORD/DT_DWORD.
  - State enum IDLE/CHECK/SETUP/STROBE/RELEASE/DONE.
  - RW_READ/RW_WRITE constants.
- One sub-module, load_extend: combinational (dtype, signed_ld, word) -> 64-bit formatted result. Reused by the writeback mux.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rdata=0x00000000_DEADBEEF, err=0, done 5 cycles after accept, MOV high exactly one contiguous window per access.
- Memory holds 0x80 at 0x20; load byte with signed_ld=1 -> rdata=0xFFFFFFFF_FFFFFF80; with signed_ld=0 -> 0x00000000_00000080.
- Doubleword store of 0x11223344_55667788 at 0xFC, then doubleword load at 0xFC -> two MOV pulses separated by a MOV=0 cycle; second Address=0x00; rdata matches the stored value.
- Halfword load at 0x21 -> err=1, done after 2 cycles, MOV never asserted.
- MOC model held low -> err=1 after TIMEOUT STROBE cycles, MOV deasserted; reset asserted during STROBE -> MOV=0 next cycle, no done pulse.
- req pulsed again while busy -> ignored; exactly one done per accepted request.
